// File: rtl/ct_ifu_sram256x23_ctrl.sv
// ct_ifu_sram256x23_ctrl
//   Access controller in front of the IFU 256x23 single-port SRAM.
//   Arbitrates reads, a one-entry write buffer and a full-array invalidate
//   sweep, and drives the SRAM's active-low CEN/GWEN/WEN pins.
//
//   Optional feature: define CT_IFU_SRAM_WBUF_BYPASS_EN to let a read that
//   hits the buffered write merge the buffered data into the returned word.
//   Without it, such a read is held off one cycle while the buffer drains.
//
// Ports
//   forever_cpuclk, cpurst_b       clock, async active-low reset
//   inv_req / inv_busy             invalidate pulse / sweep in progress
//   rd_req, rd_idx / rd_grant      read request and issue strobe
//   rd_vld, rd_data                read return, one cycle after rd_grant
//   wr_req, wr_idx, wr_data,
//   wr_mask / wr_ready             buffered write (mask bit 1 = write bit)
//   sram_a, sram_cen, sram_gwen,
//   sram_d, sram_wen / sram_q      SRAM macro pins (sampled next edge)
//
// Handshake: a write transfers on a cycle where wr_req and wr_ready are both
// high; wr_ready does not depend on wr_req. A read is issued only on a cycle
// where rd_grant is high; otherwise the requester keeps rd_req/rd_idx held.
module ct_ifu_sram256x23_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 23,
    parameter int STARVE_MAX = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  inv_req,
    output logic                  inv_busy,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic                  rd_grant,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  init_cnt;
    logic                   wbuf_vld;
    logic [ADDR_WIDTH-1:0]  wbuf_idx;
    logic [DATA_WIDTH-1:0]  wbuf_data;
    logic [DATA_WIDTH-1:0]  wbuf_mask;
    logic [SW-1:0]          starve_cnt;
    logic [DATA_WIDTH-1:0]  rd_hold;
    logic [DATA_WIDTH-1:0]  rd_now;

    logic wbuf_hit;
    logic starve_win;
    logic rd_block;
    logic drain;

    assign wbuf_hit   = wbuf_vld & (rd_idx == wbuf_idx);
    assign starve_win = wbuf_vld & (starve_cnt == STARVE_LIM);

`ifdef CT_IFU_SRAM_WBUF_BYPASS_EN
    assign rd_block = 1'b0;
`else
    // A read of the buffered index would see stale array data: let the
    // drain go first, the read wins the following cycle.
    assign rd_block = wbuf_hit;
`endif

    assign inv_busy = (state == ST_INIT);
    assign wr_ready = (state == ST_IDLE) & ~wbuf_vld;

    // Arbiter and SRAM pin drive. Gated by cpurst_b so the macro sees an
    // idle interface for as long as reset is held.
    always_comb begin
        rd_grant  = 1'b0;
        drain     = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (cpurst_b) begin
            if (state == ST_INIT) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = init_cnt;
            end else if (!inv_req) begin
                if (starve_win)
                    drain = 1'b1;
                else if (rd_req && !rd_block)
                    rd_grant = 1'b1;
                else if (wbuf_vld)
                    drain = 1'b1;

                if (rd_grant) begin
                    sram_cen  = 1'b0;
                    sram_a    = rd_idx;
                end else if (drain) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_a    = wbuf_idx;
                    sram_d    = wbuf_data;
                    sram_wen  = ~wbuf_mask;
                end
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            wbuf_vld   <= 1'b0;
            wbuf_idx   <= '0;
            wbuf_data  <= '0;
            wbuf_mask  <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == {ADDR_WIDTH{1'b1}})
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (inv_req) begin
                        state      <= ST_INIT;
                        wbuf_vld   <= 1'b0;
                        starve_cnt <= '0;
                    end else begin
                        if (drain) begin
                            wbuf_vld   <= 1'b0;
                            starve_cnt <= '0;
                        end else if (rd_grant && wbuf_vld && starve_cnt != STARVE_LIM) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        // wr_ready implies the buffer is empty, so this never
                        // collides with a drain in the same cycle.
                        if (wr_req && wr_ready) begin
                            wbuf_vld  <= 1'b1;
                            wbuf_idx  <= wr_idx;
                            wbuf_data <= wr_data;
                            wbuf_mask <= wr_mask;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

`ifdef CT_IFU_SRAM_WBUF_BYPASS_EN
    logic [DATA_WIDTH-1:0] byp_data;
    logic [DATA_WIDTH-1:0] byp_mask;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            byp_data <= '0;
            byp_mask <= '0;
        end else if (rd_grant) begin
            byp_data <= wbuf_data;
            byp_mask <= wbuf_hit ? wbuf_mask : '0;
        end
    end

    assign rd_now = (sram_q & ~byp_mask) | (byp_data & byp_mask);
`else
    assign rd_now = sram_q;
`endif

    // sram_q is only meaningful in the cycle after a read, so the returned
    // word is taken live on rd_vld and held in rd_hold afterwards.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld  <= 1'b0;
            rd_hold <= '0;
        end else begin
            rd_vld <= rd_grant;
            if (rd_vld)
                rd_hold <= rd_now;
        end
    end

    assign rd_data = rd_vld ? rd_now : rd_hold;

endmodule

// File: tb/tb_ct_ifu_sram256x23_ctrl.sv
// tb_ct_ifu_sram256x23_ctrl
//   Directed bench for ct_ifu_sram256x23_ctrl with a behavioural 256x23
//   single-port SRAM attached to the pins. Inputs change 1 ns after the
//   rising edge; outputs are checked 1 ns later.
module tb_ct_ifu_sram256x23_ctrl;

    logic        clk;
    logic        cpurst_b;
    logic        inv_req;
    logic        inv_busy;
    logic        rd_req;
    logic [7:0]  rd_idx;
    logic        rd_grant;
    logic        rd_vld;
    logic [22:0] rd_data;
    logic        wr_req;
    logic [7:0]  wr_idx;
    logic [22:0] wr_data;
    logic [22:0] wr_mask;
    logic        wr_ready;
    logic [7:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [22:0] sram_d;
    logic [22:0] sram_wen;
    logic [22:0] sram_q;

    int n_checks = 0;
    int n_err    = 0;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ct_ifu_sram256x23_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .inv_req        (inv_req),
        .inv_busy       (inv_busy),
        .rd_req         (rd_req),
        .rd_idx         (rd_idx),
        .rd_grant       (rd_grant),
        .rd_vld         (rd_vld),
        .rd_data        (rd_data),
        .wr_req         (wr_req),
        .wr_idx         (wr_idx),
        .wr_data        (wr_data),
        .wr_mask        (wr_mask),
        .wr_ready       (wr_ready),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_d         (sram_d),
        .sram_wen       (sram_wen),
        .sram_q         (sram_q)
    );

    // SRAM model. Filled with junk while reset is held so the sweep has
    // something to clear.
    logic [22:0] mem [256];

    always @(posedge clk) begin
        if (!cpurst_b) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= 23'($urandom) | 23'h1;
        end else if (!sram_cen) begin
            if (!sram_gwen)
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= mem[sram_a];
        end
    end

    // Driver / checker helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},   32'(inv_busy), 32'd1);
        chk({tag, "_ctl"},    32'({sram_cen, sram_gwen, rd_grant, wr_ready, rd_vld}), 32'b11000);
        chk({tag, "_wen"},    32'(sram_wen), 32'h7FFFFF);
        chk({tag, "_a"},      32'(sram_a), 32'd0);
        chk({tag, "_d"},      32'(sram_d), 32'd0);
        chk({tag, "_rddata"}, 32'(rd_data), 32'd0);
    endtask

    // Checks n sweep cycles starting at index first, advancing a cycle each.
    task automatic sweep(input string tag, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            chk({tag, "_a"}, 32'(sram_a), 32'(i));
            chk({tag, "_ctl"},
                32'({sram_cen, sram_gwen, rd_grant, wr_ready, inv_busy, |sram_wen, |sram_d}),
                32'b0000100);
            step();
        end
    endtask

    task automatic do_read(input logic [7:0] idx);
        rd_req = 1'b1;
        rd_idx = idx;
        step();
        rd_req = 1'b0;
        #1;
    endtask

    initial begin
        cpurst_b = 1'b0;
        inv_req  = 1'b0;
        rd_req   = 1'b0;
        rd_idx   = '0;
        wr_req   = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        wr_mask  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");

        // T1: sweep after reset release, then a read of a cleared word
        cpurst_b = 1'b1;
        #1;
        sweep("init", 0, 256);
        chk("init_done", 32'({inv_busy, wr_ready, sram_cen}), 32'b011);
        rd_req = 1'b1;
        rd_idx = 8'h10;
        #1;
        chk("t1_grant", 32'({rd_grant, sram_cen, sram_gwen}), 32'b101);
        chk("t1_a", 32'(sram_a), 32'h10);
        step();
        rd_req = 1'b0;
        #1;
        chk("t1_vld", 32'(rd_vld), 32'd1);
        chk("t1_data", 32'(rd_data), 32'd0);

        // T2: full-mask write drains on its own, then read back
        step();
        wr_req  = 1'b1;
        wr_idx  = 8'h20;
        wr_data = 23'h7FFFFF;
        wr_mask = 23'h7FFFFF;
        #1;
        chk("t2_ready", 32'(wr_ready), 32'd1);
        chk("t2_nodrain_same", 32'(sram_cen), 32'd1);
        step();
        wr_req = 1'b0;
        #1;
        chk("t2_drain_ctl", 32'({sram_cen, sram_gwen, wr_ready}), 32'b000);
        chk("t2_drain_wen", 32'(sram_wen), 32'd0);
        chk("t2_drain_a", 32'(sram_a), 32'h20);
        chk("t2_drain_d", 32'(sram_d), 32'h7FFFFF);
        step();
        chk("t2_empty", 32'({wr_ready, sram_cen}), 32'b11);
        do_read(8'h20);
        chk("t2_rd", 32'({rd_vld, rd_data}), {8'h0, 1'b1, 23'h7FFFFF});
        step();
        chk("t2_hold", 32'({rd_vld, rd_data}), {8'h0, 1'b0, 23'h7FFFFF});

        // T3: reads held on other indices starve the write for 4 cycles
        wr_req  = 1'b1;
        wr_idx  = 8'h30;
        wr_data = 23'h012345;
        wr_mask = 23'h7FFFFF;
        rd_req  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rd_idx = 8'h40 + 8'(k);
            #1;
            if (k == 5) begin
                chk("t3_starve_grant", 32'(rd_grant), 32'd0);
                chk("t3_starve_drain", 32'({sram_cen, sram_gwen, sram_a}), {22'h0, 2'b00, 8'h30});
            end else begin
                chk("t3_grant", 32'(rd_grant), 32'd1);
                chk("t3_rd_a", 32'(sram_a), 32'(8'h40 + 8'(k)));
            end
            if (k == 6)
                chk("t3_vld_gap", 32'(rd_vld), 32'd0);
            step();
            wr_req = 1'b0;
        end
        rd_req = 1'b0;
        #1;
        do_read(8'h30);
        chk("t3_rd_back", 32'(rd_data), 32'h012345);

        // T4: read of the buffered index, partial mask
        step();
        wr_req  = 1'b1;
        wr_idx  = 8'h05;
        wr_data = 23'h00000F;
        wr_mask = 23'h000003;
        step();
        wr_req = 1'b0;
        rd_req = 1'b1;
        rd_idx = 8'h05;
        #1;
`ifdef CT_IFU_SRAM_WBUF_BYPASS_EN
        chk("t4_byp_grant", 32'(rd_grant), 32'd1);
        step();
        rd_req = 1'b0;
        #1;
        chk("t4_byp_data", 32'({rd_vld, rd_data}), {8'h0, 1'b1, 23'h000003});
        chk("t4_byp_drain", 32'({sram_cen, sram_gwen, sram_a}), {22'h0, 2'b00, 8'h05});
        step();
`else
        chk("t4_blk_grant", 32'(rd_grant), 32'd0);
        chk("t4_blk_drain", 32'({sram_cen, sram_gwen, sram_a}), {22'h0, 2'b00, 8'h05});
        chk("t4_blk_wen", 32'(sram_wen), 32'h7FFFFC);
        step();
        chk("t4_late_grant", 32'(rd_grant), 32'd1);
        step();
        rd_req = 1'b0;
        #1;
        chk("t4_data", 32'({rd_vld, rd_data}), {8'h0, 1'b1, 23'h000003});
`endif

        // T5: invalidate with a buffered write and a read pending
        wr_req  = 1'b1;
        wr_idx  = 8'h20;
        wr_data = 23'h055555;
        wr_mask = 23'h7FFFFF;
        rd_req  = 1'b1;
        rd_idx  = 8'h60;
        step();
        wr_req  = 1'b0;
        inv_req = 1'b1;
        rd_idx  = 8'h61;
        #1;
        chk("t5_inv_ctl", 32'({rd_grant, sram_cen, wr_ready}), 32'b010);
        step();
        inv_req = 1'b0;
        #1;
        sweep("inv", 0, 10);
        inv_req = 1'b1;
        #1;
        sweep("inv_ign", 10, 1);
        inv_req = 1'b0;
        #1;
        sweep("inv2", 11, 245);
        rd_req = 1'b0;
        #1;
        chk("t5_done", 32'({inv_busy, wr_ready, sram_cen}), 32'b011);
        do_read(8'h20);
        chk("t5_cleared", 32'({rd_vld, rd_data}), {8'h0, 1'b1, 23'h0});

        // T6: async reset in the middle of a sweep
        step();
        do_read(8'h30);
        chk("t6_pre_data", 32'(rd_data), 32'd0);
        step();
        inv_req = 1'b1;
        step();
        inv_req = 1'b0;
        #1;
        sweep("t6", 0, 100);
        chk("t6_at100", 32'(sram_a), 32'd100);
        cpurst_b = 1'b0;
        #1;
        chk_reset("t6_rst");
        step();
        cpurst_b = 1'b1;
        #1;
        sweep("t6_restart", 0, 256);
        chk("t6_done", 32'({inv_busy, wr_ready}), 32'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
